// File: rtl/mux_scan_n.sv
// Channel selector with a manual mode and an auto-scan mode.
// Scan mode steps through the unmasked channels and holds each one for DWELL cycles.
//
// state  | meaning
// IDLE   | disabled; outputs hold and sal_valid is low
// MANUAL | sal follows the channel picked by sel
// SCAN   | sal follows the scan pointer, which advances through the mask
module mux_scan_n #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DWELL    = 4,
  localparam int SELW    = $clog2(CHANNELS),
  localparam int CW      = $clog2(DWELL + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS-1:0]       mask,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [WIDTH-1:0]          sal,
  output logic [SELW-1:0]           ch,
  output logic                      sal_valid,
  output logic                      err,
  output logic                      wrap
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [CW-1:0]   cnt;
  logic            reload;

  logic [SELW-1:0] low_idx, nxt_idx, adv_idx;
  logic            any_mask, have_higher, mask_cur, sel_bad, adv;

  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] idx);
    pick = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (idx == SELW'(i)) pick = d[i*WIDTH +: WIDTH];
  endfunction

  // Downward loops leave the lowest matching index as the winner.
  always_comb begin
    low_idx     = '0;
    nxt_idx     = '0;
    have_higher = 1'b0;
    mask_cur    = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = SELW'(i);
      if (mask[i] && (SELW'(i) > ptr)) begin
        nxt_idx     = SELW'(i);
        have_higher = 1'b1;
      end
      if (ptr == SELW'(i)) mask_cur = mask[i];
    end
    any_mask = |mask;
    adv_idx  = have_higher ? nxt_idx : low_idx;
    adv      = (cnt == CW'(DWELL - 1)) || !mask_cur;
    sel_bad  = 32'(sel) >= CHANNELS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      reload    <= 1'b0;
      sal       <= '0;
      ch        <= '0;
      sal_valid <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      cnt       <= '0;
      sal_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (!mode) begin
      state <= MANUAL;
      wrap  <= 1'b0;
      ch    <= sel;
      if (sel_bad) begin
        sal       <= '0;
        sal_valid <= 1'b0;
        err       <= 1'b1;
      end else begin
        sal       <= pick(sel);
        sal_valid <= 1'b1;
        err       <= 1'b0;
      end
    end else begin
      state <= SCAN;
      err   <= 1'b0;
      wrap  <= 1'b0;
      if (!any_mask) begin
        // Empty mask parks the scan; the next nonzero mask restarts from the bottom.
        sal_valid <= 1'b0;
        reload    <= 1'b1;
      end else if (state != SCAN || reload) begin
        reload    <= 1'b0;
        ptr       <= low_idx;
        cnt       <= '0;
        sal       <= pick(low_idx);
        ch        <= low_idx;
        sal_valid <= 1'b1;
      end else if (adv) begin
        ptr       <= adv_idx;
        cnt       <= '0;
        sal       <= pick(adv_idx);
        ch        <= adv_idx;
        sal_valid <= 1'b1;
        wrap      <= !have_higher;
      end else begin
        cnt       <= cnt + CW'(1);
        sal       <= pick(ptr);
        ch        <= ptr;
        sal_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter WIDTH, default 8: bits per channel, legal range 1..32.
REQ-003 Parameter DWELL, default 4: cycles each channel is held in scan mode, legal range 1..255.
REQ-004 Derived constant SELW = clog2(CHANNELS); it is not a user parameter.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 en  in  1  block enable; 0 forces IDLE.
REQ-008 mode  in  1  0 = manual select, 1 = automatic scan.
REQ-009 sel  in  SELW  channel index used in manual mode.
REQ-010 mask  in  CHANNELS  per-channel enable for scan mode; bit i = 1 means channel i is scanned.
REQ-011 d  in  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 sal  out  WIDTH  registered selected data.
REQ-013 ch  out  SELW  registered index of the channel currently driving sal.
REQ-014 sal_valid  out  1  sal/ch hold a legal selection.
REQ-015 err  out  1  registered; illegal manual sel (sel >= CHANNELS).
REQ-016 wrap  out  1  one-cycle pulse when the scan pointer wraps from highest to lowest enabled channel.

Function
REQ-017 FSM states: IDLE, MANUAL, SCAN; state is re-evaluated every cycle from en/mode.
REQ-018 Transitions: en=0 -> IDLE; en=1 & mode=0 -> MANUAL; en=1 & mode=1 -> SCAN; any state reaches any state in one cycle.
REQ-019 IDLE: sal, ch, err hold their last values; sal_valid=0; wrap=0; dwell counter cleared.
REQ-020 MANUAL: latency is exactly 1 cycle; sal <= d[sel], ch <= sel, sal_valid <= 1, err <= 0, all registered from the inputs of the previous edge.
REQ-021 MANUAL with sel >= CHANNELS: sal <= 0, ch <= sel, sal_valid <= 0, err <= 1.
REQ-022 SCAN entry (from IDLE or MANUAL): pointer loads the lowest-index unmasked channel; dwell counter loads 0.
REQ-023 SCAN: every cycle sal <= d[pointer], ch <= pointer, sal_valid <= 1, err <= 0; data is live, sampled each cycle rather than once per dwell.
REQ-024 SCAN dwell: the counter counts 0..DWELL-1; on DWELL-1 it reloads 0 and the pointer advances to the next unmasked channel with a higher index.
REQ-025 If no higher unmasked channel exists, the pointer wraps to the lowest unmasked channel and wrap pulses 1 for that one cycle.
REQ-026 A single unmasked channel stays selected; wrap pulses every DWELL cycles.
REQ-027 mask = 0 in SCAN: sal_valid=0, sal holds, pointer and counter hold, wrap=0; on the first cycle mask becomes nonzero, the pointer loads the lowest unmasked channel and the counter loads 0.
REQ-028 If mask changes mid-dwell and clears the current pointer's bit, the pointer moves on the next edge to the next unmasked channel (wrapping per REQ-025), the counter reloads 0, and wrap behaves per REQ-025.
REQ-029 DWELL=1: the pointer advances every cycle.
REQ-030 Counter width is clog2(DWELL+1); it never exceeds DWELL-1.

Reset
REQ-031 rst_n=0 immediately, without a clock, forces state=IDLE, sal=0, ch=0, sal_valid=0, err=0, wrap=0, pointer=0, counter=0.
REQ-032 Reset asserted mid-scan aborts the dwell; after release the block starts per REQ-018/REQ-022 with no residual pointer.
REQ-033 The first edge after rst_n rises is a normal functional edge.

Verification (CHANNELS=4, WIDTH=8, DWELL=2, d = {8'h44,8'h33,8'h22,8'h11})
REQ-034 Manual sweep: en=1, mode=0, sel=0,1,2,3 one per cycle -> next cycle sal=11,22,33,44; ch matches sel; sal_valid=1; err=0.
REQ-035 Scan, mask=4'b1111 -> ch sequence 0,0,1,1,2,2,3,3,0; wrap=1 only on the cycle ch returns to 0.
REQ-036 Scan, mask=4'b1010 -> ch 1,1,3,3,1; sal 22,22,44,44,22; wrap on each return to 1.
REQ-037 Scan, mask cleared to 0 mid-dwell -> sal_valid=0 next cycle and sal holds; mask=4'b0100 -> ch=2, sal=33, sal_valid=1 next cycle.
REQ-038 Async reset mid-scan at ch=2 -> outputs 0 with no clock edge; release with mode=1 -> scan restarts at ch=0.
REQ-039 Parameterised CHANNELS=3: manual sel=3 -> err=1, sal_valid=0, sal=0; sel=2 -> err=0.
